// File: rtl/io_pwr_pkg.sv
// Package io_pwr_pkg
// Shared types and defaults for the EG1.8V IO ring power sequencer.
// Contents:
//   io_pwr_state_e    - 3-bit sequencer state encoding (also driven on state_o)
//   io_pwr_dn_phase_e - sub-step inside PWR_DN (oe off, ie off, ret on)
//   io_pwr_out_t      - registered pad/handshake output bundle
//   DEB_CYC_DEF, STEP_CYC_DEF, CNT_W_DEF - default timing constants
//   decode_outputs()  - output decode from (state, power-down phase)
package io_pwr_pkg;

  localparam int unsigned DEB_CYC_DEF  = 16;
  localparam int unsigned STEP_CYC_DEF = 8;
  localparam int unsigned CNT_W_DEF    = 8;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_REL_RET  = 3'd2,
    ST_IE_ON    = 3'd3,
    ST_READY    = 3'd4,
    ST_PWR_DN   = 3'd5,
    ST_FAULT    = 3'd6
  } io_pwr_state_e;

  typedef enum logic [1:0] {
    DN_OE_OFF = 2'd0,
    DN_IE_OFF = 2'd1,
    DN_RET_ON = 2'd2
  } io_pwr_dn_phase_e;

  typedef struct packed {
    logic ack;
    logic ret;
    logic ie;
    logic oe;
    logic fault;
  } io_pwr_out_t;

  // Pads held in retention, gates closed, no ack, no fault.
  localparam io_pwr_out_t OUT_OFF = '{ack: 1'b0, ret: 1'b1, ie: 1'b0, oe: 1'b0, fault: 1'b0};

  // Ack stays high through PWR_DN so the controller sees it fall only once
  // the ring is fully back in retention (OFF). FAULT drops ack immediately.
  function automatic io_pwr_out_t decode_outputs(input io_pwr_state_e st,
                                                 input io_pwr_dn_phase_e ph);
    io_pwr_out_t o;
    o = OUT_OFF;
    case (st)
      ST_REL_RET: o.ret = 1'b0;
      ST_IE_ON: begin
        o.ret = 1'b0;
        o.ie  = 1'b1;
      end
      ST_READY: begin
        o.ret = 1'b0;
        o.ie  = 1'b1;
        o.oe  = 1'b1;
        o.ack = 1'b1;
      end
      ST_PWR_DN: begin
        o.ack = 1'b1;
        o.ret = (ph == DN_RET_ON);
        o.ie  = (ph == DN_OE_OFF);
      end
      ST_FAULT: o.fault = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/io_ring_pwr_seq_if.sv
// Interface io_ring_pwr_seq_if
// Handshake between the SoC power controller and the IO ring sequencer.
//   pwr_req_i  controller -> sequencer  level request (1 = IO up, 0 = IO down)
//   pwr_ack_o  sequencer -> controller  1 in READY and during PWR_DN, 0 otherwise
//   fault_o    sequencer -> controller  sticky supply-loss flag
//   state_o    sequencer -> controller  current state (io_pwr_state_e encoding)
// Handshake: four-phase level protocol. The controller raises pwr_req_i and
// holds it; the sequencer raises pwr_ack_o once the ring is fully enabled.
// The controller drops pwr_req_i; the sequencer drops pwr_ack_o once the ring
// is back in retention. A request change is only acted on in OFF, DEBOUNCE,
// READY and FAULT; in FAULT, pwr_req_i low is the acknowledgement that clears it.
interface io_ring_pwr_seq_if;
  logic       pwr_req_i;
  logic       pwr_ack_o;
  logic       fault_o;
  logic [2:0] state_o;

  modport master (output pwr_req_i, input pwr_ack_o, fault_o, state_o);
  modport slave  (input pwr_req_i, output pwr_ack_o, fault_o, state_o);
endinterface

// File: rtl/io_sync2.sv
// Module io_sync2
// Two-flop synchronizer for a single asynchronous level.
// Ports: clk, rst_n (async active-low), d (async input), q (synced, 2-cycle latency).
// Parameter RST_VAL: value both flops take in reset.
module io_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q      <= RST_VAL;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end
endmodule

// File: rtl/io_ring_pwr_seq.sv
// Module io_ring_pwr_seq
// Power sequencer for the EG1.8V IO pad ring. Debounces the ring supply-good
// level, then releases retention, enables inputs, enables outputs, each
// STEP_CYC apart; powers down in reverse order. Supply loss outside OFF and
// DEBOUNCE forces the pads safe in one cycle and latches a fault.
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   supply_ok_i    asynchronous ring supply-good from pad level detector
//   ctl            io_ring_pwr_seq_if.slave (pwr_req_i, pwr_ack_o, fault_o, state_o)
//   pad_ret_o      pad retention/isolation, active high
//   pad_ie_en_o    global input-enable gate
//   pad_oe_en_o    global output-enable gate
//   fault_cnt_o    [7:0] saturating FAULT entry count (only with IO_PWR_SEQ_STATUS_EN)
// Configuration macro: IO_PWR_SEQ_STATUS_EN adds fault_cnt_o.
// All outputs are registered from the next-state decode.
module io_ring_pwr_seq
  import io_pwr_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEB_CYC_DEF,
  parameter int unsigned STEP_CYC = STEP_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    supply_ok_i,
  io_ring_pwr_seq_if.slave        ctl,
  output logic                    pad_ret_o,
  output logic                    pad_ie_en_o,
  output logic                    pad_oe_en_o
`ifdef IO_PWR_SEQ_STATUS_EN
  ,
  output logic [7:0]              fault_cnt_o
`endif
);

  localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;
  localparam bit CFG_OK = (DEB_CYC >= 2) && (STEP_CYC >= 1) &&
                          (64'(DEB_CYC) < CNT_LIM) && (64'(STEP_CYC) < CNT_LIM);

  if (!CFG_OK) begin : g_cfg_err
    $error("io_ring_pwr_seq: CNT_W too small for DEB_CYC/STEP_CYC, or DEB_CYC<2 / STEP_CYC<1");
  end

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);

  logic             sok;
  io_pwr_state_e    state_q, state_n;
  io_pwr_dn_phase_e phase_q, phase_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_inc;
  io_pwr_out_t      out_q;

  io_sync2 #(.RST_VAL(1'b0)) u_sync_sok (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (supply_ok_i),
    .q     (sok)
  );

  // Saturating increment: the counter is never allowed to wrap.
  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      phase_q <= DN_OE_OFF;
      cnt_q   <= '0;
      out_q   <= OUT_OFF;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      cnt_q   <= cnt_n;
      out_q   <= decode_outputs(state_n, phase_n);
    end
  end

  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    cnt_n   = cnt_q;
    case (state_q)
      ST_OFF: begin
        if (ctl.pwr_req_i) begin
          state_n = ST_DEBOUNCE;
          cnt_n   = '0;
        end
      end
      ST_DEBOUNCE: begin
        if (!ctl.pwr_req_i) begin
          state_n = ST_OFF;
          cnt_n   = '0;
        end else if (!sok) begin
          cnt_n = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_n = ST_REL_RET;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_REL_RET, ST_IE_ON: begin
        if (!sok) begin
          state_n = ST_FAULT;
          cnt_n   = '0;
        end else if (cnt_q == STEP_LAST) begin
          state_n = (state_q == ST_REL_RET) ? ST_IE_ON : ST_READY;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_READY: begin
        if (!sok) begin
          state_n = ST_FAULT;
        end else if (!ctl.pwr_req_i) begin
          state_n = ST_PWR_DN;
          phase_n = DN_OE_OFF;
          cnt_n   = '0;
        end
      end
      ST_PWR_DN: begin
        // Request changes are ignored here; only supply loss can interrupt.
        if (!sok) begin
          state_n = ST_FAULT;
          cnt_n   = '0;
        end else if (cnt_q == STEP_LAST) begin
          cnt_n = '0;
          case (phase_q)
            DN_OE_OFF: phase_n = DN_IE_OFF;
            DN_IE_OFF: phase_n = DN_RET_ON;
            default: begin
              state_n = ST_OFF;
              phase_n = DN_OE_OFF;
            end
          endcase
        end else begin
          cnt_n = cnt_inc;
        end
      end
      ST_FAULT: begin
        if (!ctl.pwr_req_i) begin
          state_n = ST_OFF;
          phase_n = DN_OE_OFF;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = ST_OFF;
        phase_n = DN_OE_OFF;
        cnt_n   = '0;
      end
    endcase
  end

  assign ctl.pwr_ack_o = out_q.ack;
  assign ctl.fault_o   = out_q.fault;
  assign ctl.state_o   = state_q;
  assign pad_ret_o     = out_q.ret;
  assign pad_ie_en_o   = out_q.ie;
  assign pad_oe_en_o   = out_q.oe;

`ifdef IO_PWR_SEQ_STATUS_EN
  logic [7:0] fault_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt_q <= 8'd0;
    end else if ((state_q != ST_FAULT) && (state_n == ST_FAULT) && (fault_cnt_q != 8'hFF)) begin
      fault_cnt_q <= fault_cnt_q + 8'd1;
    end
  end

  assign fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Testbench tb_io_ring_pwr_seq
// Directed sequences against io_ring_pwr_seq. Each sequence pushes the output
// events it expects ({cycle, state/ack/ret/ie/oe/fault}) into exp_q; a monitor
// on the falling edge pops one entry whenever the output vector changes.
module tb_io_ring_pwr_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic supply_ok = 1'b0;
  logic pad_ret, pad_ie, pad_oe;
`ifdef IO_PWR_SEQ_STATUS_EN
  logic [7:0] fault_cnt;
`endif

  io_ring_pwr_seq_if ctl_if ();

  io_ring_pwr_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .supply_ok_i (supply_ok),
    .ctl         (ctl_if),
    .pad_ret_o   (pad_ret),
    .pad_ie_en_o (pad_ie),
    .pad_oe_en_o (pad_oe)
`ifdef IO_PWR_SEQ_STATUS_EN
    ,
    .fault_cnt_o (fault_cnt)
`endif
  );

  // Vector layout: {state[2:0], ack, ret, ie, oe, fault}
  localparam logic [7:0] V_OFF = 8'h08;
  localparam logic [7:0] V_DEB = 8'h28;
  localparam logic [7:0] V_REL = 8'h40;
  localparam logic [7:0] V_IE  = 8'h64;
  localparam logic [7:0] V_RDY = 8'h96;
  localparam logic [7:0] V_DN0 = 8'hB4;
  localparam logic [7:0] V_DN1 = 8'hB0;
  localparam logic [7:0] V_DN2 = 8'hB8;
  localparam logic [7:0] V_FLT = 8'hC9;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  logic [39:0] exp_q[$];
  logic [7:0] prev_vec = 8'hFF;

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_at(input int dc, input logic [7:0] v);
    exp_q.push_back({32'(base + dc), v});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [7:0]  cur;
    logic [39:0] e;
    cur = {ctl_if.state_o, ctl_if.pwr_ack_o, pad_ret, pad_ie, pad_oe, ctl_if.fault_o};
    if (cur !== prev_vec) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got=%h expected none", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if (e !== {32'(cyc), cur}) begin
          failures++;
          $display("FAIL output_event got cyc=%0d vec=%h expected cyc=%0d vec=%h",
                   cyc, cur, e[39:8], e[7:0]);
        end
      end
      prev_vec = cur;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    ctl_if.pwr_req_i = 1'b0;
    base = 0;
    expect_at(1, V_OFF);            // reset values at first sample
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);

    // Power-up with supply and request raised together (includes sync latency).
    base = cyc;
    expect_at(1, V_DEB); expect_at(18, V_REL); expect_at(26, V_IE); expect_at(34, V_RDY);
    supply_ok = 1'b1;
    ctl_if.pwr_req_i = 1'b1;
    tick(40);

    // Power-down; a short request pulse during PWR_DN must be ignored.
    base = cyc;
    expect_at(1, V_DN0); expect_at(9, V_DN1); expect_at(17, V_DN2); expect_at(25, V_OFF);
    ctl_if.pwr_req_i = 1'b0;
    tick(5);
    ctl_if.pwr_req_i = 1'b1;
    tick(2);
    ctl_if.pwr_req_i = 1'b0;
    tick(30);

    // Power-up with a one-cycle supply glitch after the count reaches 10.
    base = cyc;
    expect_at(1, V_DEB); expect_at(30, V_REL); expect_at(38, V_IE); expect_at(46, V_RDY);
    ctl_if.pwr_req_i = 1'b1;
    tick(11);
    supply_ok = 1'b0;
    tick(1);
    supply_ok = 1'b1;
    tick(45);

    // Power-down with request re-raised mid-sequence and held: restart after OFF.
    base = cyc;
    expect_at(1, V_DN0); expect_at(9, V_DN1); expect_at(17, V_DN2); expect_at(25, V_OFF);
    expect_at(26, V_DEB); expect_at(42, V_REL); expect_at(50, V_IE); expect_at(58, V_RDY);
    ctl_if.pwr_req_i = 1'b0;
    tick(12);
    ctl_if.pwr_req_i = 1'b1;
    tick(55);

    // Supply loss in READY; supply return must not leave FAULT; req low clears.
    base = cyc;
    expect_at(3, V_FLT); expect_at(11, V_OFF);
    supply_ok = 1'b0;
    tick(5);
    supply_ok = 1'b1;
    tick(5);
    ctl_if.pwr_req_i = 1'b0;
    tick(10);

`ifdef IO_PWR_SEQ_STATUS_EN
    checks++;
    if (fault_cnt !== 8'd1) begin
      failures++;
      $display("FAIL fault_cnt_first got=%0d expected=1", fault_cnt);
    end
    for (int i = 0; i < 300; i++) begin
      base = cyc;
      expect_at(1, V_DEB); expect_at(17, V_REL); expect_at(20, V_FLT); expect_at(21, V_OFF);
      ctl_if.pwr_req_i = 1'b1;
      tick(17);
      supply_ok = 1'b0;
      tick(3);
      supply_ok = 1'b1;
      ctl_if.pwr_req_i = 1'b0;
      tick(4);
    end
    checks++;
    if (fault_cnt !== 8'd255) begin
      failures++;
      $display("FAIL fault_cnt_sat got=%0d expected=255", fault_cnt);
    end
`endif

    // Asynchronous reset while in IE_ON.
    base = cyc;
    expect_at(1, V_DEB); expect_at(17, V_REL); expect_at(25, V_IE); expect_at(28, V_OFF);
    ctl_if.pwr_req_i = 1'b1;
    tick(28);
    rst_n = 1'b0;
    ctl_if.pwr_req_i = 1'b0;
    tick(3);
`ifdef IO_PWR_SEQ_STATUS_EN
    checks++;
    if (fault_cnt !== 8'd0) begin
      failures++;
      $display("FAIL fault_cnt_reset got=%0d expected=0", fault_cnt);
    end
`endif
    rst_n = 1'b1;
    tick(6);

    // ---------------- final report ----------------
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got=%0d outstanding expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
